// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: loads a WIDTH-bit word and emits it one bit per cycle,
// with a ready/valid load handshake, hold/freeze, and gapless back-to-back words.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             xvalid_q, xvalid_d;
    logic             last_q, last_d;

    logic             atLast;
    logic             doLoad;
    logic [CW-1:0]    cntInc;
    logic             dinFirst;
    logic [WIDTH-1:0] dinRest;
    logic             shregNext;
    logic [WIDTH-1:0] shregRest;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            x_q      <= 1'b0;
            xvalid_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            xvalid_q <= xvalid_d;
            last_q   <= last_d;
        end
    end

    // The first bit goes straight to x on load; the shift register keeps only the remaining bits.
    always_comb begin
        dinFirst  = MSB_FIRST ? din[WIDTH-1] : din[0];
        dinRest   = MSB_FIRST ? (din << 1) : (din >> 1);
        shregNext = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        shregRest = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cntInc    = cnt_q + CW'(1);
        atLast    = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        xvalid_d = xvalid_q;
        last_d   = last_q;

        load_ready = (state_q == IDLE) || (atLast && !hold);
        doLoad     = load_valid && load_ready;

        case (state_q)
            IDLE: begin
                x_d      = 1'b0;
                xvalid_d = 1'b0;
                last_d   = 1'b0;
                cnt_d    = '0;
                if (doLoad) begin
                    state_d  = SHIFT;
                    shreg_d  = dinRest;
                    x_d      = dinFirst;
                    xvalid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (doLoad) begin
                        shreg_d  = dinRest;
                        cnt_d    = '0;
                        x_d      = dinFirst;
                        xvalid_d = 1'b1;
                        last_d   = 1'b0;
                    end else if (atLast) begin
                        state_d  = IDLE;
                        shreg_d  = '0;
                        cnt_d    = '0;
                        x_d      = 1'b0;
                        xvalid_d = 1'b0;
                        last_d   = 1'b0;
                    end else begin
                        shreg_d = shregRest;
                        cnt_d   = cntInc;
                        x_d     = shregNext;
                        last_d  = (cntInc == CNT_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign x       = x_q;
    assign x_valid = xvalid_q;
    assign last    = last_q;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance,
// checked against hand-computed bit streams.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dinM, dinL;
    logic       lvM, lvL, holdM, holdL;
    logic       readyM, readyL;
    logic       xM, xL, xvM, xvL, lastM, lastL, busyM, busyL;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutM (
        .clk(clk), .rst(rst), .din(dinM), .load_valid(lvM), .load_ready(readyM),
        .hold(holdM), .x(xM), .x_valid(xvM), .last(lastM), .busy(busyM)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutL (
        .clk(clk), .rst(rst), .din(dinL), .load_valid(lvL), .load_ready(readyL),
        .hold(holdL), .x(xL), .x_valid(xvL), .last(lastL), .busy(busyL)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change one time unit after the edge; outputs are sampled after a further settle.
    task automatic applyStimulus(input logic [7:0] d, input logic lv, input logic h);
        dinM  = d;
        lvM   = lv;
        holdM = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] expStream;
    logic [10:0] expHold;
    logic [7:0]  expLsb;

    initial begin
        rst = 1'b1; dinL = 8'h00; lvL = 1'b0; holdL = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset x", xM, 0);
        checkOutput("reset x_valid", xvM, 0);
        checkOutput("reset last", lastM, 0);
        checkOutput("reset busy", busyM, 0);
        checkOutput("reset load_ready", readyM, 1);

        // basic word: 8'hEC MSB first
        expStream = 16'b11101100_00000000;
        applyStimulus(8'hEC, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("basic x[%0d]", i), xM, expStream[15-i]);
            checkOutput($sformatf("basic xv[%0d]", i), xvM, 1);
            checkOutput($sformatf("basic last[%0d]", i), lastM, (i == 7));
            checkOutput($sformatf("basic busy[%0d]", i), busyM, 1);
            tick();
        end
        checkOutput("basic idle busy", busyM, 0);
        checkOutput("basic idle xv", xvM, 0);
        checkOutput("basic idle ready", readyM, 1);

        // back-to-back: EC then A5, no gap
        expStream = 16'b11101100_10100101;
        applyStimulus(8'hEC, 1'b1, 1'b0);
        tick();
        applyStimulus(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'hA5, (i < 8), 1'b0);
            checkOutput($sformatf("b2b x[%0d]", i), xM, expStream[15-i]);
            checkOutput($sformatf("b2b xv[%0d]", i), xvM, 1);
            checkOutput($sformatf("b2b last[%0d]", i), lastM, (i % 8 == 7));
            checkOutput($sformatf("b2b ready[%0d]", i), readyM, (i % 8 == 7));
            tick();
        end
        checkOutput("b2b idle busy", busyM, 0);
        checkOutput("b2b idle xv", xvM, 0);

        // hold: freeze on bit index 2 for three edges
        expHold = 11'b111111_01100;
        applyStimulus(8'hEC, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(8'h00, 1'b0, (k >= 3 && k <= 5));
            checkOutput($sformatf("hold x[%0d]", k), xM, expHold[11-k]);
            checkOutput($sformatf("hold xv[%0d]", k), xvM, 1);
            checkOutput($sformatf("hold last[%0d]", k), lastM, (k == 11));
            checkOutput($sformatf("hold ready[%0d]", k), readyM, (k == 11));
            if (k >= 3 && k <= 6)
                checkOutput($sformatf("hold cnt[%0d]", k), dutM.cnt_q, 2);
            tick();
        end
        checkOutput("hold idle busy", busyM, 0);

        // reset mid-word, then a clean 8'h80
        applyStimulus(8'hFF, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rstmid x[%0d]", i), xM, 1);
            if (i < 3) tick();
        end
        rst = 1'b1;
        applyStimulus(8'hFF, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("rstmid x", xM, 0);
        checkOutput("rstmid xv", xvM, 0);
        checkOutput("rstmid last", lastM, 0);
        checkOutput("rstmid busy", busyM, 0);
        checkOutput("rstmid ready", readyM, 1);
        expStream = 16'b10000000_00000000;
        applyStimulus(8'h80, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("reload x[%0d]", i), xM, expStream[15-i]);
            checkOutput($sformatf("reload last[%0d]", i), lastM, (i == 7));
            tick();
        end
        checkOutput("reload idle xv", xvM, 0);

        // LSB first: 8'h01
        expLsb = 8'b10000000;
        dinL = 8'h01; lvL = 1'b1;
        tick();
        lvL = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("lsb x[%0d]", i), xL, expLsb[7-i]);
            checkOutput($sformatf("lsb xv[%0d]", i), xvL, 1);
            checkOutput($sformatf("lsb last[%0d]", i), lastL, (i == 7));
            tick();
        end
        checkOutput("lsb idle busy", busyL, 0);

        // load ignored mid-word: 8'hB6 LSB first, attempt to load 8'h00 at cnt=3
        expLsb = 8'b01101101;
        dinL = 8'hB6; lvL = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            dinL = 8'h00;
            lvL  = (i == 3);
            #1;
            checkOutput($sformatf("ign x[%0d]", i), xL, expLsb[7-i]);
            checkOutput($sformatf("ign ready[%0d]", i), readyL, (i == 7));
            tick();
        end
        lvL = 1'b0;
        checkOutput("ign idle busy", busyL, 0);
        checkOutput("ign idle xv", xvL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
